// File: rtl/ch_scan_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// ch_scan_sequencer_pkg
// Shared address map for the channel-mux register memory, plus the scan
// FSM state type used by ch_scan_sequencer.
//   ADDR_WIDTH / DATA_WIDTH  : register memory bus widths
//   CH_MUX_ENABLE            : register holding the enabled-channel mask
//   CH_MUX_SELECTOR          : register holding the selected channel index
// ---------------------------------------------------------------------------
package ch_scan_sequencer_pkg;

  localparam int ADDR_WIDTH = 8;
  localparam int DATA_WIDTH = 16;

  localparam logic [ADDR_WIDTH-1:0] CH_MUX_ENABLE   = 8'h20;
  localparam logic [ADDR_WIDTH-1:0] CH_MUX_SELECTOR = 8'h24;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WR_ENA = 3'd1,
    ST_WR_SEL = 3'd2,
    ST_DWELL  = 3'd3,
    ST_WR_OFF = 3'd4
  } scan_state_t;

endpackage

// File: rtl/ch_scan_sequencer_next_sel.sv
// ---------------------------------------------------------------------------
// ch_next_sel
// Combinational wrap-around next-set-bit finder.
//   i_mask : channel enable mask
//   i_cur  : current channel index
//   o_next : next higher set bit of i_mask after i_cur, wrapping to the
//            lowest set bit; returns i_cur when i_cur is the only set bit
//            (and also when the mask is empty).
// ---------------------------------------------------------------------------
module ch_next_sel #(
  parameter int NCH  = 4,
  parameter int CH_W = 2
) (
  input  logic [NCH-1:0]  i_mask,
  input  logic [CH_W-1:0] i_cur,
  output logic [CH_W-1:0] o_next
);

  logic w_found;
  int   w_idx;

  // Search cur+1, cur+2, ..., cur+NCH (mod NCH); the last candidate is cur
  // itself, which covers the single-bit-mask case.
  always_comb begin
    o_next  = i_cur;
    w_found = 1'b0;
    w_idx   = 0;
    for (int i = 1; i <= NCH; i++) begin
      w_idx = (int'(i_cur) + i) % NCH;
      if (!w_found && i_mask[w_idx]) begin
        o_next  = CH_W'(w_idx);
        w_found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ch_scan_sequencer.sv
// ---------------------------------------------------------------------------
// ch_scan_sequencer
// Scans the enabled analog-mux channels: writes the enable mask once, then
// writes the selector register for each enabled channel in turn, dwelling a
// programmable number of cycles on each. A host port shares the register
// memory bus and is granted in IDLE and DWELL.
//   i_clk, i_rst          : clock, asynchronous active-high reset
//   i_start, i_stop       : one-cycle scan start / stop pulses
//   i_ch_mask, i_dwell    : scan mask and dwell cycles, captured on start
//   i_host_req/wr/addr/data : host bus request
//   o_host_gnt            : host owns the bus this cycle
//   o_addr, o_data, o_wr  : register memory bus
//   o_busy                : sequencer not idle
//   o_ch_cur              : channel currently selected
// ---------------------------------------------------------------------------
module ch_scan_sequencer
  import ch_scan_sequencer_pkg::*;
#(
  parameter int DWELL_W = 16,
  parameter int NCH     = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  logic                  i_stop,
  input  logic [NCH-1:0]        i_ch_mask,
  input  logic [DWELL_W-1:0]    i_dwell,
  input  logic                  i_host_req,
  input  logic                  i_host_wr,
  input  logic [ADDR_WIDTH-1:0] i_host_addr,
  input  logic [DATA_WIDTH-1:0] i_host_data,
  output logic                  o_host_gnt,
  output logic [ADDR_WIDTH-1:0] o_addr,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_wr,
  output logic                  o_busy,
  output logic [1:0]            o_ch_cur
);

  localparam int CH_W = 2;

  scan_state_t          r_state;
  scan_state_t          w_next_state;
  logic [NCH-1:0]       r_mask;
  logic [DWELL_W-1:0]   r_dwell;
  logic [DWELL_W-1:0]   r_cnt;
  logic [CH_W-1:0]      r_ch;
  logic                 r_stop_pend;

  logic                 w_start_ok;
  logic                 w_stop;
  logic                 w_host_gnt;
  logic                 w_expire;
  logic [DWELL_W-1:0]   w_dwell_eff;
  logic [CH_W-1:0]      w_first_ch;
  logic [CH_W-1:0]      w_adv_ch;

  // Lowest set bit == "next after the top index" with wrap-around.
  ch_next_sel #(.NCH(NCH), .CH_W(CH_W)) u_first_sel (
    .i_mask (i_ch_mask),
    .i_cur  (CH_W'(NCH-1)),
    .o_next (w_first_ch)
  );

  ch_next_sel #(.NCH(NCH), .CH_W(CH_W)) u_adv_sel (
    .i_mask (r_mask),
    .i_cur  (r_ch),
    .o_next (w_adv_ch)
  );

  // A stop in the same cycle as start wins, so the start is dropped.
  assign w_start_ok  = i_start && !i_stop && (i_ch_mask != '0);
  // A live stop pulse acts immediately; the pending flag holds it otherwise.
  assign w_stop      = i_stop || r_stop_pend;
  assign w_host_gnt  = i_host_req && ((r_state == ST_IDLE) || (r_state == ST_DWELL));
  assign w_dwell_eff = (r_dwell == '0) ? DWELL_W'(1) : r_dwell;
  // Expiry is held off while the host owns the bus; the count stays at 1.
  assign w_expire    = (r_state == ST_DWELL) && (r_cnt == DWELL_W'(1)) &&
                       !w_host_gnt && !w_stop;

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:   if (w_start_ok) w_next_state = ST_WR_ENA;
      ST_WR_ENA: w_next_state = w_stop ? ST_WR_OFF : ST_WR_SEL;
      ST_WR_SEL: w_next_state = w_stop ? ST_WR_OFF : ST_DWELL;
      ST_DWELL: begin
        if (w_stop)        w_next_state = ST_WR_OFF;
        else if (w_expire) w_next_state = ST_WR_SEL;
      end
      ST_WR_OFF: w_next_state = ST_IDLE;
      default:   w_next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    o_host_gnt = 1'b0;
    o_wr       = 1'b0;
    o_addr     = '0;
    o_data     = '0;
    case (r_state)
      ST_WR_ENA: begin
        o_wr   = 1'b1;
        o_addr = CH_MUX_ENABLE;
        o_data = {{(DATA_WIDTH-NCH){1'b0}}, r_mask};
      end
      ST_WR_SEL: begin
        o_wr   = 1'b1;
        o_addr = CH_MUX_SELECTOR;
        o_data = {{(DATA_WIDTH-CH_W){1'b0}}, r_ch};
      end
      ST_WR_OFF: begin
        o_wr   = 1'b1;
        o_addr = CH_MUX_ENABLE;
        o_data = '0;
      end
      default: begin
        if (w_host_gnt) begin
          o_host_gnt = 1'b1;
          o_wr       = i_host_wr;
          o_addr     = i_host_addr;
          o_data     = i_host_data;
        end
      end
    endcase
  end

  assign o_busy   = (r_state != ST_IDLE);
  assign o_ch_cur = r_ch;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= ST_IDLE;
      r_mask      <= '0;
      r_dwell     <= '0;
      r_cnt       <= '0;
      r_ch        <= '0;
      r_stop_pend <= 1'b0;
    end else begin
      r_state <= w_next_state;

      if (r_state == ST_WR_OFF)
        r_stop_pend <= 1'b0;
      else if (i_stop && (r_state != ST_IDLE))
        r_stop_pend <= 1'b1;

      if ((r_state == ST_IDLE) && w_start_ok) begin
        r_mask  <= i_ch_mask;
        r_dwell <= i_dwell;
        r_ch    <= w_first_ch;
      end else if (w_expire) begin
        r_ch    <= w_adv_ch;
      end

      if (r_state == ST_WR_SEL)
        r_cnt <= w_dwell_eff;
      else if ((r_state == ST_DWELL) && (r_cnt != DWELL_W'(1)))
        r_cnt <= r_cnt - DWELL_W'(1);
    end
  end

endmodule

// File: tb/tb_ch_scan_sequencer.sv
module tb_ch_scan_sequencer;
  import ch_scan_sequencer_pkg::*;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  start, stop;
  logic [3:0]            ch_mask;
  logic [15:0]           dwell;
  logic                  host_req, host_wr;
  logic [ADDR_WIDTH-1:0] host_addr;
  logic [DATA_WIDTH-1:0] host_data;
  logic                  host_gnt;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] data;
  logic                  wr, busy;
  logic [1:0]            ch_cur;

  always #5 clk = ~clk;

  ch_scan_sequencer #(.DWELL_W(16), .NCH(4)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_start     (start),
    .i_stop      (stop),
    .i_ch_mask   (ch_mask),
    .i_dwell     (dwell),
    .i_host_req  (host_req),
    .i_host_wr   (host_wr),
    .i_host_addr (host_addr),
    .i_host_data (host_data),
    .o_host_gnt  (host_gnt),
    .o_addr      (addr),
    .o_data      (data),
    .o_wr        (wr),
    .o_busy      (busy),
    .o_ch_cur    (ch_cur)
  );

  typedef struct {
    logic [ADDR_WIDTH-1:0] a;
    logic [DATA_WIDTH-1:0] d;
    int                    gap;   // cycles since previous sequencer write, -1 = don't care
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   last_wr = 0;

  always @(posedge clk) cyc++;

  // Scoreboard: every sequencer-driven write must match the next expectation.
  always @(negedge clk) begin : mon
    exp_t e;
    if (wr && !host_gnt) begin
      checks++;
      assert (q.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_wr addr=%0h data=%0h expected none", addr, data);
      end
      if (q.size() != 0) begin
        e = q.pop_front();
        checks++;
        assert (addr === e.a) else begin
          errors++;
          $error("FAIL wr_addr obs=%0h exp=%0h", addr, e.a);
        end
        checks++;
        assert (data === e.d) else begin
          errors++;
          $error("FAIL wr_data obs=%0h exp=%0h", data, e.d);
        end
        if (e.gap >= 0) begin
          checks++;
          assert ((cyc - last_wr) === e.gap) else begin
            errors++;
            $error("FAIL wr_period obs=%0d exp=%0d", cyc - last_wr, e.gap);
          end
        end
      end
      last_wr = cyc;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [ADDR_WIDTH-1:0] a, input logic [DATA_WIDTH-1:0] d, input int gap);
    exp_t e;
    e.a = a; e.d = d; e.gap = gap;
    q.push_back(e);
  endtask

  task automatic push_sel(input int ch, input int gap);
    push(CH_MUX_SELECTOR, DATA_WIDTH'(ch), gap);
  endtask

  // Returns in the first DWELL cycle after the last expected write.
  task automatic wait_drain(input int budget);
    int n = 0;
    while (q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    checks++;
    assert (q.size() == 0) else begin
      errors++;
      $error("FAIL drain_timeout pending=%0d exp=0", q.size());
      q.delete();
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Stop from a DWELL cycle: the next cycle writes ENABLE=0, then IDLE.
  task automatic do_stop(input string tag);
    push(CH_MUX_ENABLE, '0, -1);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk({tag, "_busy_off_wr"}, 32'(busy), 32'd1);
    tick();
    chk({tag, "_busy_idle"}, 32'(busy), 32'd0);
    chk({tag, "_q_empty"}, q.size(), 32'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0; ch_mask = '0; dwell = '0;
    host_req = 1'b0; host_wr = 1'b0; host_addr = '0; host_data = '0;
    tick(); tick();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ch",   32'(ch_cur), 32'd0);
    chk("rst_wr",   32'(wr), 32'd0);
    chk("rst_gnt",  32'(host_gnt), 32'd0);
    chk("rst_addr", 32'(addr), 32'd0);
    rst = 1'b0;
    tick();

    // Host access in IDLE is granted combinationally.
    host_req = 1'b1; host_wr = 1'b1; host_addr = 8'h5A; host_data = 16'hBEEF;
    #1;
    chk("idle_gnt",  32'(host_gnt), 32'd1);
    chk("idle_addr", 32'(addr), 32'h5A);
    chk("idle_data", 32'(data), 32'hBEEF);
    chk("idle_wr",   32'(wr), 32'd1);
    host_req = 1'b0;
    #1;
    chk("idle_nogn", 32'(host_gnt), 32'd0);
    chk("idle_bus0", {8'(addr), 16'(data), 7'd0, wr}, 32'd0);

    // Empty mask: start ignored, no writes.
    ch_mask = 4'b0000; dwell = 16'd3;
    pulse_start();
    chk("mask0_busy", 32'(busy), 32'd0);
    repeat (3) tick();
    chk("mask0_busy2", 32'(busy), 32'd0);

    // Start and stop together in IDLE: stop wins.
    ch_mask = 4'b1111;
    start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    chk("ss_busy", 32'(busy), 32'd0);
    tick();
    chk("ss_busy2", 32'(busy), 32'd0);

    // mask 1011, dwell 3: SEL 0,1,3,0,1 every 4 cycles; mid-scan input changes ignored.
    ch_mask = 4'b1011; dwell = 16'd3;
    push(CH_MUX_ENABLE, 16'h000B, -1);
    push_sel(0, 1); push_sel(1, 4); push_sel(3, 4); push_sel(0, 4); push_sel(1, 4);
    pulse_start();
    chk("s1_busy", 32'(busy), 32'd1);
    chk("s1_first", 32'(ch_cur), 32'd0);
    ch_mask = 4'b0001; dwell = 16'd7;
    wait_drain(40);
    chk("s1_cur", 32'(ch_cur), 32'd1);
    do_stop("s1");

    // dwell 0 behaves as 1: SEL 2 every 2 cycles.
    ch_mask = 4'b0100; dwell = 16'd0;
    push(CH_MUX_ENABLE, 16'h0004, -1);
    push_sel(2, 1); push_sel(2, 2); push_sel(2, 2); push_sel(2, 2);
    pulse_start();
    wait_drain(20);
    chk("s2_cur", 32'(ch_cur), 32'd2);
    do_stop("s2");

    // Host held from WR_ENA through WR_SEL: granted in first DWELL cycle.
    ch_mask = 4'b0010; dwell = 16'd3;
    push(CH_MUX_ENABLE, 16'h0002, -1);
    push_sel(1, 1);
    pulse_start();
    host_req = 1'b1; host_wr = 1'b1; host_addr = 8'h33; host_data = 16'h1234;
    #1;
    chk("h_ena_gnt", 32'(host_gnt), 32'd0);
    chk("h_ena_addr", 32'(addr), 32'(CH_MUX_ENABLE));
    tick();
    chk("h_sel_gnt", 32'(host_gnt), 32'd0);
    chk("h_sel_addr", 32'(addr), 32'(CH_MUX_SELECTOR));
    tick();
    chk("h_dw_gnt",  32'(host_gnt), 32'd1);
    chk("h_dw_addr", 32'(addr), 32'h33);
    chk("h_dw_data", 32'(data), 32'h1234);
    chk("h_dw_wr",   32'(wr), 32'd1);
    host_req = 1'b0;
    push_sel(1, 4); push_sel(1, 4);
    wait_drain(20);
    do_stop("s3");

    // Host grant on the dwell-expiry cycle delays WR_SEL by one.
    ch_mask = 4'b0010; dwell = 16'd1;
    push(CH_MUX_ENABLE, 16'h0002, -1);
    push_sel(1, 1); push_sel(1, 2);
    pulse_start();
    wait_drain(20);
    push_sel(1, 3); push_sel(1, 2);
    host_req = 1'b1; host_wr = 1'b0; host_addr = 8'h44; host_data = 16'h0;
    #1;
    chk("exp_gnt", 32'(host_gnt), 32'd1);
    chk("exp_wr",  32'(wr), 32'd0);
    tick();
    host_req = 1'b0;
    wait_drain(20);
    do_stop("s4");

    // Asynchronous reset mid-DWELL, then restart from lowest set bit.
    ch_mask = 4'b1100; dwell = 16'd5;
    push(CH_MUX_ENABLE, 16'h000C, -1);
    push_sel(2, 1);
    pulse_start();
    wait_drain(20);
    tick();
    chk("pre_rst_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    chk("ar_busy", 32'(busy), 32'd0);
    chk("ar_ch",   32'(ch_cur), 32'd0);
    chk("ar_wr",   32'(wr), 32'd0);
    chk("ar_gnt",  32'(host_gnt), 32'd0);
    tick();
    rst = 1'b0;
    tick();
    chk("post_rst_busy", 32'(busy), 32'd0);
    push(CH_MUX_ENABLE, 16'h000C, -1);
    push_sel(2, 1); push_sel(3, 6);
    pulse_start();
    chk("rs_first", 32'(ch_cur), 32'd2);
    wait_drain(30);
    do_stop("s5");

    repeat (3) tick();
    chk("final_q", q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout obs=running exp=finished");
    $fatal(1, "watchdog");
  end

endmodule
